// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting agents and rr_arbiter8.
// The master side drives requests; the slave side (the arbiter) returns
// the one-hot grant, the winner index, busy and the timeout pulse.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant.
// A grant is held until the winner drops its request; there is no preemption.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a grant that has been
// held for MAX_HOLD consecutive cycles is forcibly released with a one-cycle
// timeout pulse. When undefined, no hold counter exists and timeout is 0.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] grant_idx_q;
    logic [7:0] grant_q;
    logic       busy_q;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;
    logic       any_req;
    logic       released;

    // Elaboration-time guard on the hold limit
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter8: MAX_HOLD must be in 1..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;
    logic          timeout_q;
    logic          expire;

    assign expire = (hold_cnt == CW'(MAX_HOLD - 1));
`endif

    assign any_req  = |bus.req;
    assign released = !bus.req[grant_idx_q];

    // Scan requests starting at the pointer and wrapping, first hit wins
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Arbitration FSM: pick a winner from IDLE, hold it in GRANT until release
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            grant_idx_q <= 3'd0;
            grant_q     <= 8'h00;
            busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= GRANT;
                        grant_idx_q <= winner;
                        ptr         <= winner + 3'd1;
                        grant_q     <= 8'b1 << winner;
                        busy_q      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (released) begin
                        state   <= IDLE;
                        grant_q <= 8'h00;
                        busy_q  <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (expire) begin
                        state     <= IDLE;
                        grant_q   <= 8'h00;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule
